// File: rtl/odd_even_sorter.sv
// Odd-even transposition sorter: DATA_N pipelined compare-swap stages with a
// valid/ready handshake at both ends. Each vector carries its own ascending /
// descending flag through the pipeline, so mixed modes can be in flight.
// Optional feature: define SORT_IDX_EN to tag every lane with its original
// input lane number; the tags follow their data through each swap and are
// presented on idx_o.
module odd_even_sorter #(
    parameter int DATA_W = 8,
    parameter int DATA_N = 8,
    parameter int IDX_W  = $clog2(DATA_N)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_desc,
    input  logic [DATA_N-1:0][DATA_W-1:0]  data_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_N-1:0][DATA_W-1:0]  data_o,
`ifdef SORT_IDX_EN
    output logic [DATA_N-1:0][IDX_W-1:0]   idx_o,
`endif
    output logic                           busy
);

    logic [DATA_N-1:0] stage_valid;

    for (genvar s = 0; s < DATA_N; s++) begin : g_stage
        logic [DATA_N-1:0][DATA_W-1:0] src_data;
        logic [DATA_N-1:0][DATA_W-1:0] cs_data;
        logic [DATA_N-1:0][DATA_W-1:0] data_q;
        logic                          src_valid;
        logic                          src_desc;
        logic                          valid_q;
        logic                          desc_q;
        logic                          ld;
        logic                          nxt_rdy;
`ifdef SORT_IDX_EN
        logic [DATA_N-1:0][IDX_W-1:0]  src_idx;
        logic [DATA_N-1:0][IDX_W-1:0]  cs_idx;
        logic [DATA_N-1:0][IDX_W-1:0]  idx_q;
`endif

        // Stage 0 sorts straight from the input port; later stages from the previous register.
        if (s == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_desc  = in_desc;
            assign src_data  = data_in;
`ifdef SORT_IDX_EN
            for (genvar l = 0; l < DATA_N; l++) begin : g_tag
                assign src_idx[l] = IDX_W'(l);
            end
`endif
        end else begin : g_body
            assign src_valid = g_stage[s-1].valid_q;
            assign src_desc  = g_stage[s-1].desc_q;
            assign src_data  = g_stage[s-1].data_q;
`ifdef SORT_IDX_EN
            assign src_idx   = g_stage[s-1].idx_q;
`endif
        end

        // Even stages pair (0,1),(2,3)..; odd stages pair (1,2),(3,4).. and pass the end lanes.
        // Equal values never swap, which keeps the sort stable.
        for (genvar l = 0; l < DATA_N; l++) begin : g_lane
            if (((l % 2) == (s % 2)) && (l + 1 < DATA_N)) begin : g_lo
                logic sw;
                assign sw = src_desc ? (src_data[l] < src_data[l+1])
                                     : (src_data[l] > src_data[l+1]);
                assign cs_data[l] = sw ? src_data[l+1] : src_data[l];
`ifdef SORT_IDX_EN
                assign cs_idx[l]  = sw ? src_idx[l+1] : src_idx[l];
`endif
            end else if (((l % 2) != (s % 2)) && (l >= 1)) begin : g_hi
                logic sw;
                assign sw = src_desc ? (src_data[l-1] < src_data[l])
                                     : (src_data[l-1] > src_data[l]);
                assign cs_data[l] = sw ? src_data[l-1] : src_data[l];
`ifdef SORT_IDX_EN
                assign cs_idx[l]  = sw ? src_idx[l-1] : src_idx[l];
`endif
            end else begin : g_pass
                assign cs_data[l] = src_data[l];
`ifdef SORT_IDX_EN
                assign cs_idx[l]  = src_idx[l];
`endif
            end
        end

        // Ready ripples back from the output: a stage may load if empty or if it is moving on.
        if (s == DATA_N - 1) begin : g_tail
            assign nxt_rdy = out_ready;
        end else begin : g_mid
            assign nxt_rdy = g_stage[s+1].ld;
        end
        assign ld = !valid_q || nxt_rdy;

        // Stage register: payload only changes when a valid vector is loaded.
        always_ff @(posedge clk) begin
            if (!reset) begin
                valid_q <= 1'b0;
                desc_q  <= 1'b0;
                data_q  <= '0;
`ifdef SORT_IDX_EN
                idx_q   <= '0;
`endif
            end else if (ld) begin
                valid_q <= src_valid;
                if (src_valid) begin
                    desc_q <= src_desc;
                    data_q <= cs_data;
`ifdef SORT_IDX_EN
                    idx_q  <= cs_idx;
`endif
                end
            end
        end

        assign stage_valid[s] = valid_q;
    end

    assign in_ready  = g_stage[0].ld;
    assign out_valid = g_stage[DATA_N-1].valid_q;
    assign data_o    = g_stage[DATA_N-1].data_q;
`ifdef SORT_IDX_EN
    assign idx_o     = g_stage[DATA_N-1].idx_q;
`endif
    assign busy      = |stage_valid;

endmodule

// File: tb/tb_odd_even_sorter.sv
// Scoreboard bench for odd_even_sorter (DATA_N=4, DATA_W=4). Expected results
// come from a rank-based stable sort; a negedge monitor pushes on input
// handshakes and pops/compares on output handshakes.
module tb_odd_even_sorter;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    typedef logic [N-1:0][W-1:0]  vec_t;
    typedef logic [N-1:0][IW-1:0] ivec_t;
    typedef struct {
        vec_t  d;
        ivec_t ix;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  in_valid;
    logic  in_ready;
    logic  in_desc;
    vec_t  data_in;
    logic  out_valid;
    logic  out_ready;
    vec_t  data_o;
    ivec_t idx_o;
    logic  busy;

    odd_even_sorter #(.DATA_W(W), .DATA_N(N), .IDX_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_desc   (in_desc),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
`ifdef SORT_IDX_EN
        .idx_o     (idx_o),
`endif
        .busy      (busy)
    );
`ifndef SORT_IDX_EN
    assign idx_o = '0;
`endif

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    logic chk_lat = 1'b0;
    logic hold_pend = 1'b0;
    vec_t hold_d;
    exp_t expq[$];
    int   accq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Stable sort by rank: an element's output position is the number of
    // elements strictly ahead of it in the chosen order plus equal earlier lanes.
    function automatic void ref_sort(input vec_t din, input logic desc,
                                     output vec_t dout, output ivec_t iout);
        dout = '0;
        iout = '0;
        for (int i = 0; i < N; i++) begin
            int rank;
            rank = 0;
            for (int j = 0; j < N; j++) begin
                if (desc ? (din[j] > din[i]) : (din[j] < din[i])) rank++;
                else if ((din[j] == din[i]) && (j < i)) rank++;
            end
            dout[rank] = din[i];
            iout[rank] = IW'(i);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   a;
        cyc++;
        if (!reset) begin
            expq.delete();
            accq.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && out_valid) check("hold_stable", data_o, hold_d);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0h expected none (cycle %0d)", data_o, cyc);
                end else begin
                    e = expq.pop_front();
                    a = accq.pop_front();
                    check("sorted_data", data_o, e.d);
`ifdef SORT_IDX_EN
                    check("sorted_idx", idx_o, e.ix);
`endif
                    if (chk_lat) check("latency", cyc - a, N);
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_d    = data_o;
            if (in_valid && in_ready) begin
                ref_sort(data_in, in_desc, e.d, e.ix);
                expq.push_back(e);
                accq.push_back(cyc);
                acc_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, (1 << W) - 1));
        return v;
    endfunction

    function automatic vec_t mk(input int l0, input int l1, input int l2, input int l3);
        vec_t v;
        v[0] = W'(l0); v[1] = W'(l1); v[2] = W'(l2); v[3] = W'(l3);
        return v;
    endfunction

    task automatic drain(input string name);
        int g;
        g = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((expq.size() != 0 || busy) && g < 200) begin
            step();
            g++;
        end
        check(name, expq.size(), 0);
    endtask

    initial begin
        int last;
        int g;
        int base;
        reset = 1'b0; in_valid = 1'b0; in_desc = 1'b0; data_in = '0; out_ready = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_data_o", data_o, 0);
        check("rst_idx_o", idx_o, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed back-to-back vectors with exact latency.
        chk_lat = 1'b1;
        in_valid = 1'b1; in_desc = 1'b0; data_in = mk(3, 1, 2, 0);
        step();
        in_desc = 1'b1;
        step();
        in_desc = 1'b0; data_in = mk(5, 5, 2, 5);
        step();
        in_desc = 1'b1; data_in = mk(7, 7, 9, 1);
        step();
        drain("directed_drain");
        chk_lat = 1'b0;

        // Stall: only DATA_N vectors fit, then in_ready drops.
        out_ready = 1'b0;
        base = acc_cnt;
        last = acc_cnt;
        in_valid = 1'b1; in_desc = 1'($urandom_range(0, 1)); data_in = rand_vec();
        for (int c = 0; c < 10; c++) begin
            step();
            if (acc_cnt != last) begin
                last = acc_cnt;
                in_desc = 1'($urandom_range(0, 1));
                data_in = rand_vec();
            end
        end
        check("stall_accepted", acc_cnt - base, N);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        drain("stall_drain");

        // Reset with three vectors in flight.
        in_valid = 1'b1; data_in = rand_vec(); in_desc = 1'b0;
        step();
        data_in = rand_vec(); in_desc = 1'b1;
        step();
        data_in = rand_vec();
        step();
        in_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        for (int c = 0; c < 8; c++) begin
            step();
            check("midrst_no_stale", out_valid, 0);
        end

        // Random traffic with random modes and backpressure.
        base = acc_cnt;
        g = 0;
        while ((acc_cnt - base) < 10000 && g < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_desc   = 1'($urandom_range(0, 1));
            data_in   = rand_vec();
            step();
            g++;
        end
        check("random_count", acc_cnt - base, 10000);
        drain("random_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
